// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state enum, bytes-per-word constant and default base address.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAST,
    ST_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;

  // Byte address of word index idx relative to a word-aligned base.
  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [31:0] idx
  );
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// 8->32 big-endian word assembler: shifts bytes in MSB-first.
// Ports: clk, reset, i_clr, i_fire, i_data -> o_word, o_word_valid.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_fire,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_shift;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_fire) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_shift <= {r_shift[15:0], i_data};
    end
  end

  // The 4th byte completes the word combinationally so the
  // write can be registered at the very edge that accepts it.
  assign o_word       = {r_shift, i_data};
  assign o_word_valid = i_fire &&
                        (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream in, word writes out.
// Ports: clk, reset, start, num_words, in_data/in_valid/in_ready,
//        wr_en/wr_addr/wr_data, cpu_hold, done, checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] num_words,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wr_en,
  output logic [31:0]     wr_addr,
  output logic [31:0]     wr_data,
  output logic            cpu_hold,
  output logic            done,
  output logic [31:0]     checksum
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W:0]   r_num;
  logic [ADDR_W-1:0] r_index;
  logic              r_wr_en;
  logic [31:0]       r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [31:0]       r_checksum;
  logic              r_hold;
  logic              r_done;

  logic              w_start_acc;
  logic              w_in_ready;
  logic              w_fire;
  logic              w_last_word;
  logic [31:0]       w_word;
  logic              w_word_valid;

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_start_acc),
    .i_fire       (w_fire),
    .i_data       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_in_ready  = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next = (num_words == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (w_word_valid && w_last_word) w_next = ST_LAST;
      end
      ST_LAST: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_fire = in_valid && w_in_ready;

  // Compared in ADDR_W+1 bits so a full 2^ADDR_W load still
  // terminates; the index wrap after that write is harmless.
  assign w_last_word = ({1'b0, r_index} == (r_num - 1'b1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num      <= '0;
      r_index    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= '0;
      r_checksum <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= w_word_valid;
      if (w_start_acc) begin
        r_num      <= num_words;
        r_index    <= '0;
        r_checksum <= '0;
      end
      if (w_word_valid) begin
        r_wr_data  <= w_word;
        r_wr_addr  <= word_addr(BASE_ADDR, 32'(r_index));
        r_checksum <= r_checksum ^ w_word;
        r_index    <= r_index + 1'b1;
      end
      // Processor is released exactly when DONE is entered.
      r_done <= (w_next == ST_DONE);
      r_hold <= (w_next != ST_DONE);
    end
  end

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_hold;
  assign done     = r_done;
  assign checksum = r_checksum;

endmodule
